// File: rtl/stack_guard_pkg.sv
// Shared definitions for the CPU hardware-stack guard.
// Holds the stack geometry so the stack memory and stack_guard agree, plus the
// guard FSM state encoding.
package stack_guard_pkg;

  localparam int unsigned STACK_DEPTH = 128;
  localparam int unsigned STACK_W     = 32;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDefer = 2'd1,
    StFault = 2'd2
  } state_e;

endpackage

// File: rtl/stack_guard.sv
// stack_guard: sole driver of the CPU hardware stack's push/pop/clear/hold inputs.
// Tracks occupancy, blocks overflow/underflow, splits a simultaneous push+pop into
// a pop followed by a deferred push, and raises sticky error flags plus a
// one-cycle interrupt.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_req_push/i_req_pop    execute-stage requests, i_req_data push data
//   i_clear, i_hold         pipeline flush / stall (forwarded to the stack)
//   i_err_ack               clears sticky flags and leaves FAULT
//   i_stk_q                 stack read data, valid the cycle after a pop
//   o_stk_d/o_stk_push/o_stk_pop/o_stk_clear/o_stk_hold   stack controls
//   o_pop_data/o_pop_valid  popped word returned to the pipeline
//   o_busy                  deferred push pending
//   o_depth/o_full/o_empty  occupancy
//   o_err_overflow/o_err_underflow/o_err_irq  error reporting
module stack_guard
  import stack_guard_pkg::*;
#(
  parameter int unsigned DEPTH       = STACK_DEPTH,
  parameter int unsigned DEPTH_W     = $clog2(DEPTH),
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req_push,
  input  logic               i_req_pop,
  input  logic [STACK_W-1:0] i_req_data,
  input  logic               i_clear,
  input  logic               i_hold,
  input  logic               i_err_ack,
  input  logic [STACK_W-1:0] i_stk_q,
  output logic [STACK_W-1:0] o_stk_d,
  output logic               o_stk_push,
  output logic               o_stk_pop,
  output logic               o_stk_clear,
  output logic               o_stk_hold,
  output logic [STACK_W-1:0] o_pop_data,
  output logic               o_pop_valid,
  output logic               o_busy,
  output logic [DEPTH_W:0]   o_depth,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_err_overflow,
  output logic               o_err_underflow,
  output logic               o_err_irq
);

  localparam logic [DEPTH_W:0] FullCnt = DEPTH[DEPTH_W:0];

  state_e             r_state;
  logic [DEPTH_W:0]   r_depth;
  logic [STACK_W-1:0] r_defer_data;
  logic               r_ovf;
  logic               r_udf;
  logic               r_irq;
  logic               r_pop_valid;
  logic               r_pop_real;   // pop_valid came from a real pop, not an underflow

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_fwd_pop;
  logic w_do_pop;
  logic w_do_push;
  logic w_defer_issue;
  logic w_defer_push;
  logic w_ovf_err;
  logic w_udf_err;
  logic w_err;

  assign w_full  = (r_depth == FullCnt);
  assign w_empty = (r_depth == '0);

  // Requests are only acted on in RUN with the pipeline neither stalled nor flushed.
  assign w_accept  = (r_state == StRun) && !i_hold && !i_clear;
  // Stalled/flushed pops still reach the stack so it applies its own hold/clear rules.
  assign w_fwd_pop = (r_state == StRun) && (i_hold || i_clear) && i_req_pop;

  assign w_do_pop  = w_accept && i_req_pop && !w_empty;
  assign w_do_push = w_accept && i_req_push && !i_req_pop && !w_full;

  // The latched push waits out a stall; a flush discards it.
  assign w_defer_issue = (r_state == StDefer) && !i_hold && !i_clear;
  assign w_defer_push  = w_defer_issue && !w_full;

  assign w_ovf_err = (w_accept && i_req_push && !i_req_pop && w_full) ||
                     (w_defer_issue && w_full);
  assign w_udf_err = w_accept && i_req_pop && w_empty;
  assign w_err     = w_ovf_err || w_udf_err;

  assign o_stk_push  = !i_reset && (w_do_push || w_defer_push);
  assign o_stk_pop   = !i_reset && (w_do_pop || w_fwd_pop);
  assign o_stk_d     = (r_state == StDefer) ? r_defer_data : i_req_data;
  assign o_stk_clear = i_clear;
  assign o_stk_hold  = i_hold;

  // The stack presents its data the cycle after the pop, alongside r_pop_valid.
  assign o_pop_data  = (r_pop_valid && r_pop_real) ? i_stk_q : '0;
  assign o_pop_valid = r_pop_valid;

  assign o_busy          = (r_state == StDefer);
  assign o_depth         = r_depth;
  assign o_full          = w_full;
  assign o_empty         = w_empty;
  assign o_err_overflow  = r_ovf;
  assign o_err_underflow = r_udf;
  assign o_err_irq       = r_irq;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StRun;
      r_depth      <= '0;
      r_defer_data <= '0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_irq        <= 1'b0;
      r_pop_valid  <= 1'b0;
      r_pop_real   <= 1'b0;
    end else begin
      r_pop_valid <= w_accept && i_req_pop;
      r_pop_real  <= w_do_pop;

      // An ack in the same cycle as a new error leaves that flag set.
      r_ovf <= (r_ovf && !i_err_ack) || w_ovf_err;
      r_udf <= (r_udf && !i_err_ack) || w_udf_err;
      // Interrupt only when the combined flag goes from clear to set.
      r_irq <= !(r_ovf || r_udf) && w_err;

      if (w_do_pop) begin
        r_depth <= r_depth - 1'b1;
      end else if (w_do_push || w_defer_push) begin
        r_depth <= r_depth + 1'b1;
      end

      unique case (r_state)
        StRun: begin
          if (w_err && HALT_ON_ERR) begin
            r_state <= StFault;
          end else if (w_accept && i_req_push && i_req_pop) begin
            r_state      <= StDefer;
            r_defer_data <= i_req_data;
          end
        end
        StDefer: begin
          if (i_clear || !i_hold) begin
            r_state      <= (w_err && HALT_ON_ERR) ? StFault : StRun;
            r_defer_data <= '0;
          end
        end
        StFault: begin
          if (i_err_ack) begin
            r_state <= StRun;
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_guard.sv
// Bench for stack_guard: two instances (HALT_ON_ERR = 1 and 0), each with a
// behavioural stack memory, checked against a queue-based reference model.
module tb_stack_guard;

  localparam int DEPTH = 128;
  localparam int M_RUN = 0, M_DEFER = 1, M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_push [2];
  logic        req_pop  [2];
  logic [31:0] req_data [2];
  logic        hold     [2];
  logic        clr      [2];
  logic        ack      [2];
  logic [31:0] stk_q    [2];
  logic [31:0] stk_d    [2];
  logic        stk_push [2];
  logic        stk_pop  [2];
  logic        stk_clear[2];
  logic        stk_hold [2];
  logic [31:0] pop_data [2];
  logic        pop_valid[2];
  logic        busy     [2];
  logic [7:0]  depth    [2];
  logic        full     [2];
  logic        empty    [2];
  logic        ovf      [2];
  logic        udf      [2];
  logic        irq      [2];

  always #5 clk = ~clk;

  stack_guard #(.DEPTH(128), .DEPTH_W(7), .HALT_ON_ERR(1'b1)) u_halt (
    .i_clk(clk), .i_reset(rst), .i_req_push(req_push[0]), .i_req_pop(req_pop[0]),
    .i_req_data(req_data[0]), .i_clear(clr[0]), .i_hold(hold[0]), .i_err_ack(ack[0]),
    .i_stk_q(stk_q[0]), .o_stk_d(stk_d[0]), .o_stk_push(stk_push[0]), .o_stk_pop(stk_pop[0]),
    .o_stk_clear(stk_clear[0]), .o_stk_hold(stk_hold[0]), .o_pop_data(pop_data[0]),
    .o_pop_valid(pop_valid[0]), .o_busy(busy[0]), .o_depth(depth[0]), .o_full(full[0]),
    .o_empty(empty[0]), .o_err_overflow(ovf[0]), .o_err_underflow(udf[0]), .o_err_irq(irq[0])
  );

  stack_guard #(.DEPTH(128), .DEPTH_W(7), .HALT_ON_ERR(1'b0)) u_run (
    .i_clk(clk), .i_reset(rst), .i_req_push(req_push[1]), .i_req_pop(req_pop[1]),
    .i_req_data(req_data[1]), .i_clear(clr[1]), .i_hold(hold[1]), .i_err_ack(ack[1]),
    .i_stk_q(stk_q[1]), .o_stk_d(stk_d[1]), .o_stk_push(stk_push[1]), .o_stk_pop(stk_pop[1]),
    .o_stk_clear(stk_clear[1]), .o_stk_hold(stk_hold[1]), .o_pop_data(pop_data[1]),
    .o_pop_valid(pop_valid[1]), .o_busy(busy[1]), .o_depth(depth[1]), .o_full(full[1]),
    .o_empty(empty[1]), .o_err_overflow(ovf[1]), .o_err_underflow(udf[1]), .o_err_irq(irq[1])
  );

  // Behavioural 128 x 32 push/pop stack memories.
  logic [31:0] mem [2][DEPTH];
  int          sp  [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        sp[k]    <= 0;
        stk_q[k] <= '0;
      end else if (stk_clear[k]) begin
        sp[k] <= 0;
      end else if (!stk_hold[k]) begin
        if (stk_push[k] && sp[k] < DEPTH) begin
          mem[k][sp[k]] <= stk_d[k];
          sp[k]         <= sp[k] + 1;
        end else if (stk_pop[k] && sp[k] > 0) begin
          stk_q[k] <= mem[k][sp[k]-1];
          sp[k]    <= sp[k] - 1;
        end
      end
    end
  end

  // Reference model of the instance under test.
  int          cur;
  bit          m_halt;
  logic [31:0] m_stk[$];
  int          m_mode;
  bit          m_ovf, m_udf, m_irq, m_pv;
  logic [31:0] m_pd, m_defd;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (inst %0d): observed %0h expected %0h", tag, cur, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_mode = M_RUN;
    m_ovf = 0; m_udf = 0; m_irq = 0; m_pv = 0;
    m_pd = '0; m_defd = '0;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      req_push[k] = 0; req_pop[k] = 0; req_data[k] = '0;
      hold[k] = 0; clr[k] = 0; ack[k] = 0;
    end
  endtask

  task automatic do_reset(input int k);
    idle_all();
    cur    = k;
    m_halt = (k == 0);
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit p, input bit o, input logic [31:0] d,
                      input bit h, input bit c, input bit a);
    bit          exp_push, exp_pop, eo, eu, was, pv;
    logic [31:0] pd;
    int          n;
    req_push[cur] = p; req_pop[cur] = o; req_data[cur] = d;
    hold[cur] = h; clr[cur] = c; ack[cur] = a;
    #2;
    n        = m_stk.size();
    exp_push = 0;
    exp_pop  = 0;
    if (m_mode == M_RUN) begin
      if (!h && !c) begin
        exp_push = p && !o && n < DEPTH;
        exp_pop  = o && n > 0;
      end else begin
        exp_pop = o;
      end
    end else if (m_mode == M_DEFER) begin
      exp_push = !h && !c && n < DEPTH;
    end
    chk("stk_push", stk_push[cur], exp_push);
    if (exp_push) chk("stk_d", stk_d[cur], (m_mode == M_DEFER) ? m_defd : d);
    chk("stk_pop", stk_pop[cur], exp_pop);
    chk("stk_hold", stk_hold[cur], h);
    chk("stk_clear", stk_clear[cur], c);
    chk("depth", depth[cur], n);
    chk("full", full[cur], n == DEPTH);
    chk("empty", empty[cur], n == 0);
    chk("busy", busy[cur], m_mode == M_DEFER);
    chk("err_overflow", ovf[cur], m_ovf);
    chk("err_underflow", udf[cur], m_udf);
    chk("err_irq", irq[cur], m_irq);
    chk("pop_valid", pop_valid[cur], m_pv);
    chk("pop_data", pop_data[cur], m_pv ? m_pd : 32'h0);

    eo = 0; eu = 0; pv = 0; pd = '0;
    was = m_ovf || m_udf;
    case (m_mode)
      M_RUN: if (!h && !c) begin
        if (o) begin
          pv = 1;
          if (n > 0) pd = m_stk.pop_back();
          else       eu = 1;
          if (p) begin m_mode = M_DEFER; m_defd = d; end
        end else if (p) begin
          if (n < DEPTH) m_stk.push_back(d);
          else           eo = 1;
        end
      end
      M_DEFER: begin
        if (c) m_mode = M_RUN;
        else if (!h) begin
          if (n < DEPTH) m_stk.push_back(m_defd);
          else           eo = 1;
          m_mode = M_RUN;
        end
      end
      default: if (a) m_mode = M_RUN;
    endcase
    if ((eo || eu) && m_halt) m_mode = M_FAULT;
    m_ovf = (m_ovf && !a) || eo;
    m_udf = (m_udf && !a) || eu;
    m_irq = !was && (m_ovf || m_udf);
    m_pv  = pv;
    m_pd  = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 4, $urandom,
           $urandom_range(0, 9) < 2, 1'b0, $urandom_range(0, 9) < 2);
    end
  endtask

  initial begin
    idle_all();
    cur = 0; m_halt = 1; model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset values while reset is held
    for (int k = 0; k < 2; k++) begin
      chk("rst_depth", depth[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_pop_valid", pop_valid[k], 0);
      chk("rst_pop_data", pop_data[k], 0);
      chk("rst_flags", {ovf[k], udf[k], irq[k]}, 0);
      chk("rst_strobes", {stk_push[k], stk_pop[k]}, 0);
    end

    // LIFO ordering on the halting instance
    do_reset(0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h11, 0, 0, 0);
    step(1, 0, 32'h22, 0, 0, 0);
    step(1, 0, 32'h33, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Fill, overflow into FAULT, ignored pop, ack
    for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom, 0, 0, 0);
    step(1, 0, 32'hDEAD, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Simultaneous push+pop, then a deferred push held by a stall
    do_reset(0);
    step(1, 0, 32'h5, 0, 0, 0);
    step(1, 1, 32'h9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 32'hA, 0, 0, 0);
    step(1, 1, 32'hB, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Pop under hold and under clear leaves depth alone
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the DEFER cycle discards the latched push
    do_reset(0);
    step(1, 0, 32'h7, 0, 0, 0);
    step(1, 1, 32'h8, 0, 0, 0);
    chk("defer_busy", busy[0], 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy[0], 0);
    chk("arst_depth", depth[0], 0);
    chk("arst_stk_push", stk_push[0], 0);
    chk("arst_pop_valid", pop_valid[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // Non-halting instance: underflow, repeated underflow, ack racing an error
    do_reset(1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h42, 0, 0, 0);
    step(1, 1, 32'h43, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic on both instances
    random_run(300);
    do_reset(0);
    step(0, 0, 0, 0, 0, 0);
    random_run(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_guard.md
Name: stack_guard

Overview:
- Sits directly upstream of the CPU hardware stack (128 x 32b, push/pop only) and is the only block that drives its push, pop, clear and hold inputs.
- Accepts push/pop requests from the execute stage and tracks stack depth.
- Blocks overflow and underflow, serialises a simultaneous push+pop into two stack operations, and raises sticky error flags plus a one-cycle interrupt pulse.
- Returns popped data to the pipeline with a valid strobe.

Parameters:
- DEPTH, 128: stack capacity in words; must equal the stack memory depth.
- DEPTH_W, $clog2(DEPTH): pointer width; the depth counter is DEPTH_W+1 bits.
- HALT_ON_ERR, 1: 1 = enter FAULT on any error; 0 = keep running with sticky flags only.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_push  in  1  push request from execute stage
- req_pop  in  1  pop request from execute stage
- req_data  in  32  push data
- clear  in  1  pipeline flush
- hold  in  1  pipeline stall
- err_ack  in  1  clears sticky flags; leaves FAULT
- stk_q  in  32  stack read data (valid the cycle after a pop)
- stk_d  out  32  stack write data
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_clear  out  1  stack clear
- stk_hold  out  1  stack hold
- pop_data  out  32  popped word
- pop_valid  out  1  pop_data valid
- busy  out  1  deferred push pending; upstream must hold its requests
- depth  out  DEPTH_W+1  current occupancy
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- err_overflow  out  1  sticky overflow flag
- err_underflow  out  1  sticky underflow flag
- err_irq  out  1  one-cycle pulse on the first error while no flag is set

Behaviour:
- Reset (async) values:
  - state = RUN, depth = 0.
  - Both error flags, err_irq, busy and pop_valid = 0.
  - Deferred-push register = 0; all stk_* strobes = 0; pop_data = 0.
- stk_clear = clear and stk_hold = hold, passed through combinationally.
- Request acceptance (state RUN, busy = 0, hold = 0, clear = 0):
  - Push only:
    - !full: stk_push = 1, stk_d = req_data, depth + 1.
    - full: push dropped, err_overflow set.
  - Pop only:
    - !empty: stk_pop = 1, depth - 1, pop_valid = 1 next cycle with pop_data = stk_q.
    - empty: stk_pop = 0, err_underflow set, pop_valid = 1 next cycle with pop_data forced to 0.
  - Push + pop together:
    - Pop is issued this cycle (same rules as pop only). req_data is latched, state goes to DEFER and busy = 1 next cycle.
    - In DEFER the latched push is issued under the push-only rules (overflow check uses the updated depth), then the block returns to RUN.
    - New requests in the DEFER cycle are ignored.
- Hold or clear asserted with req_pop:
  - stk_pop is forwarded so the stack applies its own hold/clear semantics.
  - depth is unchanged and pop_valid = 0.
  - req_push is suppressed.
- DEFER takes priority over hold: the latched push is held until hold = 0. clear in DEFER discards the latched push and returns to RUN.
- FAULT (HALT_ON_ERR = 1 only):
  - Entered on any error.
  - All requests are dropped and stk_push/stk_pop = 0; depth is frozen.
  - err_ack returns to RUN and clears both flags the next cycle.
- Error flags and interrupt:
  - With HALT_ON_ERR = 0, flags stay set until err_ack; err_ack on the same cycle as a new error leaves the flag set.
  - err_irq pulses only on a 0->1 transition of (err_overflow | err_underflow).
- Depth arithmetic:
  - Unsigned, DEPTH_W+1 bits, never wraps.
  - full and empty are combinational from depth.
- Reset mid-DEFER discards the latched push.

Decomposition:
- Shared package holds:
  - State encoding: RUN = 2'd0, DEFER = 2'd1, FAULT = 2'd2.
  - STACK_DEPTH = 128 and STACK_W = 32, so the stack memory and stack_guard agree.
- No sub-module needed; the depth counter and FSM stay inline.

Test Plan:
- Reset, push 0x11, 0x22, 0x33, then three pops -> pop_data 0x33, 0x22, 0x11, each with pop_valid one cycle after its pop; depth 3->0, empty = 1.
- Fill 128 pushes, then push 0xDEAD -> stk_push = 0, err_overflow = 1, err_irq one pulse, state FAULT; a following pop is ignored; err_ack -> RUN and flags 0.
- HALT_ON_ERR = 0, pop when empty -> pop_valid = 1 with pop_data 0, err_underflow = 1, depth stays 0; a second underflow gives no new err_irq.
- depth = 1 (top 0x5), push 0x9 + pop together -> pop returns 0x5; busy = 1 for one cycle; the next cycle stk_push with stk_d = 0x9; final depth = 1.
- Pop with hold = 1 -> stk_pop = 1, stk_hold = 1, depth unchanged, pop_valid = 0; pop with clear = 1 -> stk_clear = 1, depth unchanged.
- Assert reset asynchronously (mid-clock) in the DEFER cycle -> all outputs immediately at reset values, depth 0, latched push never issued.
